// File: rtl/afifo_pkg.sv
// Helpers shared by the write- and read-pointer blocks of the async FIFO.
package afifo_pkg;

    localparam int unsigned AFIFO_ADDR_WIDTH = 4;
    localparam int unsigned PTR_MAX_W        = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Callers zero-extend narrower pointers in and truncate the result back.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = '0;
        for (int unsigned i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter: each bit is the XOR of itself and all higher Gray bits.
module gray2bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, full/almost-full flags and occupancy for an asynchronous FIFO.
module wptr_full
    import afifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AFIFO_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  overflow
);

    localparam int unsigned   PW        = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    logic [PW-1:0]         wbin_q, wbin_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [PW-1:0]         wgray_q, wgray_d;
    logic [PW-1:0]         wcount_q, wcount_d;
    logic                  full_q, full_d;
    logic                  af_q, af_d;
    logic                  ovf_q, ovf_d;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         rgray_wrapped;
    logic                  accept;

    gray2bin #(
        .WIDTH(PW)
    ) u_rptr_g2b (
        .gray_i(rptr_gray_sync),
        .bin_o (rbin)
    );

    // Reset gates the write strobe so a pending write is dropped, not just its pointer update.
    assign accept = winc & ~full_q & ~rst;

    // The Gray code of (read pointer + depth) is the read Gray code with its top two bits flipped.
    assign rgray_wrapped = {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]};

    always_comb begin
        wbin_d   = wbin_q + PW'(accept);
        wgray_d  = PW'(bin2gray(ptr_word_t'(wbin_d)));
        wcount_d = wbin_d - rbin;
        full_d   = (wgray_d == rgray_wrapped);
        af_d     = (wcount_d >= AF_THRESH);
        ovf_d    = ovf_q | (winc & full_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q   <= '0;
            waddr_q  <= '0;
            wgray_q  <= '0;
            wcount_q <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            waddr_q  <= wbin_d[ADDR_WIDTH-1:0];
            wgray_q  <= wgray_d;
            wcount_q <= wcount_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wen         = accept;
    assign waddr       = waddr_q;
    assign wptr_gray   = wgray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wcount      = wcount_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, FIFO address bits (depth 2**ADDR_WIDTH).
REQ-002 SHALL have parameter AF_LEVEL, default 12, occupancy at or above which almost_full asserts.
REQ-003 SHALL have port clk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port winc  input  1  write request from the producer.
REQ-006 SHALL have port rptr_gray_sync  input  ADDR_WIDTH+1  read pointer, Gray-coded, already passed through the two-stage synchronizer into clk.
REQ-007 SHALL have port wen  output  1  RAM write enable.
REQ-008 SHALL have port waddr  output  ADDR_WIDTH  RAM write address.
REQ-009 SHALL have port wptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-010 SHALL have port full  output  1  FIFO full, registered.
REQ-011 SHALL have port almost_full  output  1  occupancy >= AF_LEVEL, registered.
REQ-012 SHALL have port wcount  output  ADDR_WIDTH+1  write-side occupancy estimate, registered.
REQ-013 SHALL have port overflow  output  1  sticky error: write attempted while full.

Function
REQ-014 SHALL compute accept = winc AND NOT full; wen SHALL equal accept combinationally (no added latency).
REQ-015 SHALL hold an ADDR_WIDTH+1-bit binary pointer wbin; wbin_next = wbin + accept, modulo 2**(ADDR_WIDTH+1), wrapping from all-ones to zero.
REQ-016 SHALL register waddr <= wbin_next[ADDR_WIDTH-1:0] and wptr_gray <= (wbin_next >> 1) XOR wbin_next each cycle; wptr_gray SHALL change by at most one bit per cycle.
REQ-017 SHALL register full <= 1 exactly when Gray(wbin_next) equals rptr_gray_sync with its top two bits inverted and remaining bits unchanged.
REQ-018 SHALL convert rptr_gray_sync to binary rbin (MSB-down XOR prefix) and register wcount <= (wbin_next - rbin) modulo 2**(ADDR_WIDTH+1).
REQ-019 SHALL register almost_full <= (wbin_next - rbin) >= AF_LEVEL, using the same subtraction as REQ-018.
REQ-020 SHALL set overflow to 1 on any cycle with winc=1 and full=1; it SHALL stay 1 until rst.
REQ-021 While full=1: winc SHALL be ignored, with wen=0 and pointers unchanged.
REQ-022 full SHALL deassert the cycle after rptr_gray_sync advances; the deassertion is pessimistic by the synchronizer latency, and that latency is accepted.
REQ-023 A full-to-not-full transition and a new winc in the same cycle SHALL use the registered full, so the write is refused in that cycle.

Reset
REQ-024 On rising clk with rst=1: wbin, waddr, wptr_gray, wcount SHALL be 0, and full, almost_full, overflow SHALL be 0.
REQ-025 rst SHALL take priority over winc; asserting rst mid-burst SHALL discard any pending write, with wen=0 while rst=1.

Structure
REQ-026 A shared package (afifo_pkg) SHALL hold the bin2gray and gray2bin functions and the default ADDR_WIDTH; the read-side block SHALL reuse the same package.
REQ-027 Gray-to-binary conversion SHALL be a single sub-module gray2bin, parameterised by width and purely combinational.
REQ-028 All outputs except wen SHALL come directly from flops.

Verification (ADDR_WIDTH=4, AF_LEVEL=12)
REQ-029 Reset: rst=1 for 2 cycles with winc=1 -> all outputs 0 and wen=0 throughout.
REQ-030 Fill: rptr_gray_sync=0, 16 consecutive winc -> full=1 after the 16th write, wptr_gray=5'b11000, waddr=0, wcount=16; almost_full=1 from the cycle wcount=12.
REQ-031 Overflow: with full=1, winc=1 for 3 cycles -> wen=0, wptr_gray unchanged at 5'b11000, overflow=1 and held after winc drops.
REQ-032 Drain/wrap: from full, rptr_gray_sync stepped 0 -> 5'b11000 one Gray code per cycle while writing every cycle -> wbin wraps 31->0, full tracks REQ-017 each cycle, wptr_gray never changes more than 1 bit.
REQ-033 Simultaneous: full=1 and rptr_gray_sync advances in the same cycle as winc=1 -> that write refused; next winc accepted, wcount=16 again.
REQ-034 Mid-op reset: rst=1 after 7 writes (wcount=7) -> next cycle wcount=0, waddr=0, wptr_gray=0, overflow=0.
